// File: rtl/rvfi_retire_tracker.sv
// rvfi_retire_tracker
// Numbers up to NRET RVFI retirements per cycle, checks PC continuity across and within
// cycles, runs a no-retire watchdog and folds every error source into one sticky verdict.
module rvfi_retire_tracker #(
    parameter int unsigned NRET    = 1,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ORDER_W = 64,
    parameter int unsigned ERR_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
    input  logic                    done_i,
    input  logic [ERR_W-1:0]        errcode_i,
    output logic [NRET*ORDER_W-1:0] rvfi_order,
    output logic [ORDER_W-1:0]      retired_count,
    output logic                    pass,
    output logic                    fail,
    output logic [ERR_W-1:0]        fail_code,
    output logic [ORDER_W-1:0]      fail_order
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StPass = 2'd2;
    localparam logic [1:0] StFail = 2'd3;

    localparam logic [ERR_W-1:0] ErrPc      = {{(ERR_W-1){1'b1}}, 1'b0};
    localparam logic [ERR_W-1:0] ErrTimeout = {ERR_W{1'b1}};

    // Watchdog never needs to count past TIMEOUT-1: the event fires there and the FSM stops.
    localparam int unsigned       WdogW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WdogW-1:0] WdogLast = (TIMEOUT == 0) ? '0 : WdogW'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [ORDER_W-1:0] count_q, count_d;
    logic [XLEN-1:0]    exp_pc_q, exp_pc_d;
    logic               exp_pc_vld_q, exp_pc_vld_d;
    logic [WdogW-1:0]   wdog_q, wdog_d;
    logic [ERR_W-1:0]   code_q, code_d;
    logic [ORDER_W-1:0] forder_q, forder_d;

    logic [ORDER_W-1:0] retire_cnt;
    logic               pc_err;
    logic [XLEN-1:0]    chain_pc;
    logic               chain_vld;
    logic               any_valid;
    logic               timeout;
    logic               active;

    assign any_valid = |rvfi_valid;
    assign active    = (state_q == StIdle) || (state_q == StRun);
    assign timeout   = (TIMEOUT != 0) && !any_valid && (wdog_q == WdogLast);

    // Per-lane order numbering and the PC chain walk, lowest lane first.
    // A lane chained to a lower valid lane in the same cycle is always checked; only a lane that
    // falls back on exp_pc is skipped while exp_pc is not yet known.
    always_comb begin
        retire_cnt = '0;
        pc_err     = 1'b0;
        chain_pc   = exp_pc_q;
        chain_vld  = exp_pc_vld_q;
        rvfi_order = '0;
        for (int k = 0; k < NRET; k++) begin
            rvfi_order[k*ORDER_W +: ORDER_W] = count_q + retire_cnt;
            if (rvfi_valid[k]) begin
                if (chain_vld && (rvfi_pc_rdata[k*XLEN +: XLEN] != chain_pc)) begin
                    pc_err = 1'b1;
                end
                chain_pc   = rvfi_pc_wdata[k*XLEN +: XLEN];
                chain_vld  = 1'b1;
                retire_cnt = retire_cnt + ORDER_W'(1);
            end
        end
    end

    // Next-state: prioritised event resolution; PASS/FAIL freeze everything.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        exp_pc_d     = exp_pc_q;
        exp_pc_vld_d = exp_pc_vld_q;
        wdog_d       = wdog_q;
        code_d       = code_q;
        forder_d     = forder_q;
        if (active) begin
            if (errcode_i != '0) begin
                state_d  = StFail;
                code_d   = errcode_i;
                forder_d = count_q;
            end else if (pc_err) begin
                state_d  = StFail;
                code_d   = ErrPc;
                forder_d = count_q;
            end else if (timeout) begin
                state_d  = StFail;
                code_d   = ErrTimeout;
                forder_d = count_q;
            end else begin
                count_d = count_q + retire_cnt;
                if (any_valid) begin
                    exp_pc_d     = chain_pc;
                    exp_pc_vld_d = 1'b1;
                    wdog_d       = '0;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
                if (done_i) begin
                    state_d = StPass;
                end else if (any_valid) begin
                    state_d = StRun;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            exp_pc_q     <= '0;
            exp_pc_vld_q <= 1'b0;
            wdog_q       <= '0;
            code_q       <= '0;
            forder_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            exp_pc_q     <= exp_pc_d;
            exp_pc_vld_q <= exp_pc_vld_d;
            wdog_q       <= wdog_d;
            code_q       <= code_d;
            forder_q     <= forder_d;
        end
    end

    assign retired_count = count_q;
    assign pass          = (state_q == StPass);
    assign fail          = (state_q == StFail);
    assign fail_code     = code_q;
    assign fail_order    = forder_q;

endmodule
